simplebus_mem_follower: RTL

Parametrised memory follower for the simplebus leader/follower protocol, and the successor to the fixed 3-byte, random-latency memory thread.
- Collects a multi-byte address over the 8-bit address bus and decodes a device ID from the most-significant byte.
- Serves reads after a deterministic, programmable number of wait states; accepts writes when the leader asserts dataValid.
- Adds a write-timeout abort and status outputs.
- Tristate drivers sit outside the block; many instances share one bus, each with a distinct DEV_ID.

---
 rtl/simplebus_pkg.sv | 27 ++
 rtl/simplebus_mem_array.sv | 34 +++
 rtl/simplebus_mem_follower.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/simplebus_pkg.sv
// Shared simplebus definitions.
//   BUS_W       : width of the address and data buses
//   addr_byte_t : one address/data byte
//   fol_state_e : memory follower FSM states
//   ldr_state_e : leader FSM states, kept here so leader models can reuse them
package simplebus_pkg;

  localparam int BUS_W = 8;

  typedef logic [BUS_W-1:0] addr_byte_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_ADDR,
    FS_RWAIT,
    FS_RESP,
    FS_WWAIT
  } fol_state_e;

  typedef enum logic [2:0] {
    LS_IDLE,
    LS_ADDR,
    LS_WAIT,
    LS_DATA
  } ldr_state_e;

endpackage

// File: rtl/simplebus_mem_array.sv
// Byte-wide local memory for the simplebus follower.
//   clock : write clock
//   we    : write enable, sampled on the rising edge
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : combinational read of the current contents
// The storage has no reset, so its contents survive a bus reset.
// INIT_VAL is only a power-up value for simulation.
module simplebus_mem_array
  import simplebus_pkg::*;
#(
  parameter int         MEM_AW   = 16,
  parameter addr_byte_t INIT_VAL = 8'h00
) (
  input  logic              clock,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  addr_byte_t        wdata,
  input  logic [MEM_AW-1:0] raddr,
  output addr_byte_t        rdata
);

  addr_byte_t mem_q [2**MEM_AW] = '{default: INIT_VAL};

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/simplebus_mem_follower.sv
// Simplebus memory follower.
// It collects a multi-byte address, MSB first. The MSB is the device ID.
// It answers reads after READ_LATENCY wait cycles.
// It accepts writes when the leader asserts dataValid.
// If dataValid does not arrive within WR_TIMEOUT cycles, it aborts the write.
//   clock, resetN        : bus clock, async active-low reset
//   start, read, address : leader control and address byte
//   dataIn, dvIn         : resolved bus data / dataValid
//   dataOut, dataOE      : read data and its tristate enable
//   dvOut, dvOE          : dataValid value and its tristate enable
//   busy                 : follower is not idle
//   timeoutErr           : one-cycle pulse after a write abort
//
// state    | meaning
// IDLE     | waiting for start, captures ID byte
// ADDR     | collecting remaining address bytes, ID check on first cycle
// RWAIT    | read wait states, down-counting to the response
// RESP     | single cycle driving read data and dataValid
// WWAIT    | waiting for write dataValid, optional timeout
module simplebus_mem_follower
  import simplebus_pkg::*;
#(
  parameter int         ADDR_BYTES   = 3,
  parameter addr_byte_t DEV_ID       = 8'h00,
  parameter int         MEM_AW       = 16,
  parameter int         READ_LATENCY = 2,
  parameter int         WR_TIMEOUT   = 16,
  parameter addr_byte_t INIT_VAL     = 8'h00
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       start,
  input  logic       read,
  input  addr_byte_t address,
  input  addr_byte_t dataIn,
  output addr_byte_t dataOut,
  output logic       dataOE,
  input  logic       dvIn,
  output logic       dvOut,
  output logic       dvOE,
  output logic       busy,
  output logic       timeoutErr
);

  localparam int BC_W = $clog2(ADDR_BYTES);
  localparam int WC_W = 16;
  localparam logic [BC_W-1:0] BC_FIRST = BC_W'(ADDR_BYTES - 2);

  fol_state_e        state_q, state_d;
  addr_byte_t        addr_q [ADDR_BYTES];
  logic [BC_W-1:0]   byte_cnt_q;
  logic [WC_W-1:0]   wait_cnt_q;
  logic              timeout_q;
  logic [BUS_W*ADDR_BYTES-1:0] addr_flat;
  logic [MEM_AW-1:0] mem_idx;
  logic              addr_unused;
  logic              id_miss;
  logic              last_byte;
  logic              wr_abort;
  logic              mem_we;
  addr_byte_t        mem_rdata;

  always_comb begin
    addr_flat = '0;
    for (int i = 0; i < ADDR_BYTES; i++) begin
      addr_flat[BUS_W*i +: BUS_W] = addr_q[i];
    end
  end

  // Bits between the memory index and the ID byte are don't-care and alias.
  assign mem_idx     = addr_flat[MEM_AW-1:0];
  assign addr_unused = ^addr_flat[BUS_W*ADDR_BYTES-1:MEM_AW];

  // The ID byte was registered in IDLE, so it can be checked on the first ADDR cycle.
  assign id_miss   = (byte_cnt_q == BC_FIRST) && (addr_q[ADDR_BYTES-1] != DEV_ID);
  assign last_byte = (byte_cnt_q == '0);
  assign wr_abort  = (WR_TIMEOUT != 0) && (wait_cnt_q == WC_W'(1));

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (start) state_d = FS_ADDR;
      end
      FS_ADDR: begin
        if (id_miss) begin
          state_d = FS_IDLE;
        end else if (last_byte) begin
          if (!read)                  state_d = FS_WWAIT;
          else if (READ_LATENCY == 0) state_d = FS_RESP;
          else                        state_d = FS_RWAIT;
        end
      end
      FS_RWAIT: begin
        if (wait_cnt_q == WC_W'(1)) state_d = FS_RESP;
      end
      FS_RESP: begin
        state_d = FS_IDLE;
      end
      FS_WWAIT: begin
        if (dvIn) begin
          mem_we  = 1'b1;
          state_d = FS_IDLE;
        end else if (wr_abort) begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= FS_IDLE;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < ADDR_BYTES; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      timeout_q <= 1'b0;
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            addr_q[ADDR_BYTES-1] <= address;
            byte_cnt_q           <= BC_FIRST;
          end
        end
        FS_ADDR: begin
          addr_q[byte_cnt_q] <= address;
          byte_cnt_q         <= byte_cnt_q - 1'b1;
          if (last_byte) begin
            wait_cnt_q <= read ? WC_W'(READ_LATENCY) : WC_W'(WR_TIMEOUT);
          end
        end
        FS_RWAIT: begin
          wait_cnt_q <= wait_cnt_q - 1'b1;
        end
        FS_WWAIT: begin
          if (!dvIn) begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
            if (wr_abort) timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  simplebus_mem_array #(
    .MEM_AW   (MEM_AW),
    .INIT_VAL (INIT_VAL)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (mem_idx),
    .wdata (dataIn),
    .raddr (mem_idx),
    .rdata (mem_rdata)
  );

  // Bus drive depends only on the state register, so an async reset drops it at once.
  assign dataOE     = (state_q == FS_RESP);
  assign dvOE       = (state_q == FS_RESP);
  assign dvOut      = (state_q == FS_RESP);
  assign dataOut    = (state_q == FS_RESP) ? mem_rdata : '0;
  assign busy       = (state_q != FS_IDLE);
  assign timeoutErr = timeout_q;

endmodule
